// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory, the execute redirect and decode.
// The master modport is the fetch queue's view; slave is the surrounding environment.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] instruction_r;
    logic [31:0] pc_r;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        input  id_ready,
        output id_valid,
        output instruction_r,
        output pc_r
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        output id_ready,
        input  id_valid,
        input  instruction_r,
        input  pc_r
    );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction prefetch queue: issues word fetches under a shared credit budget,
// buffers returned words with their PCs and flushes/discards on control-flow redirects.
module fetch_queue #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = CW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
    localparam logic [SW-1:0] DEPTH_SUM = SW'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] occupancy;
    logic          started;

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   word_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [AW-1:0] trk_rd;
    logic [AW-1:0] trk_wr;
    logic [31:0]   trk_mem  [DEPTH];

    logic [SW-1:0] credit_used;
    logic          redirect;
    logic          accept;
    logic          response;
    logic          drop;
    logic          push;
    logic          pop;
    logic          head_valid;

    assign redirect    = bus.redirect_valid;
    assign credit_used = {1'b0, outstanding} + {1'b0, occupancy};
    assign accept      = bus.imem_req && bus.imem_gnt;
    assign response    = bus.imem_rvalid;
    assign drop        = response && (redirect || discard != '0);
    assign push        = response && !drop;
    assign head_valid  = occupancy != '0;
    assign pop         = head_valid && bus.id_ready && !redirect;

    // started keeps imem_req low while held in reset, so requests begin after the first edge
    assign bus.imem_req      = started && (credit_used < DEPTH_SUM) && !redirect;
    assign bus.imem_addr     = fetch_pc;
    assign bus.id_valid      = head_valid;
    assign bus.instruction_r = head_valid ? word_mem[rd_ptr] : NOP_INSTR;
    assign bus.pc_r          = head_valid ? pc_mem[rd_ptr]   : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started <= 1'b0;
        end else begin
            started <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            if (accept && !response) begin
                outstanding <= outstanding + 1'b1;
            end else if (!accept && response) begin
                outstanding <= outstanding - 1'b1;
            end

            // every request still unanswered after a redirect belongs to the abandoned path
            if (redirect) begin
                fetch_pc <= bus.redirect_pc & 32'hFFFF_FFFC;
                discard  <= outstanding - CW'(response);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (response && discard != '0) begin
                    discard <= discard - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_rd <= '0;
            trk_wr <= '0;
        end else begin
            if (accept) begin
                trk_wr <= trk_wr + 1'b1;
            end
            if (response) begin
                trk_rd <= trk_rd + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (redirect) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (!push && pop) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    // Storage arrays need no reset: their contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (accept) begin
            trk_mem[trk_wr] <= fetch_pc;
        end
        if (push) begin
            word_mem[wr_ptr] <= bus.imem_rdata;
            pc_mem[wr_ptr]   <= trk_mem[trk_rd];
        end
    end

    a_rsp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        response |-> outstanding != '0);
    a_accept_within_credit: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> credit_used < DEPTH_SUM);
    a_push_not_full: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> (occupancy != DEPTH_CNT || pop));
    a_discard_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        discard <= outstanding);
    a_counters_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        outstanding <= DEPTH_CNT && occupancy <= DEPTH_CNT);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          DEPTH     = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    fetch_queue_if bus ();

    fetch_queue #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: requests in flight (oldest first, flagged if abandoned by a redirect),
    // the words the decoder should see ({word, pc}), and the next fetch address.
    logic [31:0] inflight_addr [$];
    bit          inflight_stale [$];
    logic [63:0] outq [$];
    logic [31:0] model_pc;
    bit          running;

    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h want %h", tag, observed, expected);
        end
    endtask

    task automatic resetModel();
        outq.delete();
        inflight_addr.delete();
        inflight_stale.delete();
        model_pc = RESET_PC;
        running  = 1'b0;
    endtask

    task automatic quietInputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.id_ready       = 1'b0;
        bus.imem_gnt       = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
    endtask

    // One clock cycle: entered and left at a falling edge. Checks registered outputs,
    // drives inputs, checks the request outputs, then advances the model at the rising edge.
    task automatic applyStimulus(input bit redir, input logic [31:0] rpc, input bit ready,
                                 input bit gnt, input bit rv);
        bit          exp_req;
        bit          resp;
        bit          rstale;
        logic [31:0] raddr;

        checkOutput("id_valid", 32'(bus.id_valid), 32'(outq.size() != 0));
        if (outq.size() != 0) begin
            checkOutput("instruction_r", bus.instruction_r, outq[0][63:32]);
            checkOutput("pc_r", bus.pc_r, outq[0][31:0]);
        end else begin
            checkOutput("instruction_r_empty", bus.instruction_r, NOP_INSTR);
            checkOutput("pc_r_empty", bus.pc_r, 32'h0);
        end

        resp   = rv && inflight_addr.size() != 0;
        raddr  = resp ? inflight_addr[0] : 32'h0;
        rstale = 1'b0;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.id_ready       = ready;
        bus.imem_gnt       = gnt;
        bus.imem_rvalid    = resp;
        bus.imem_rdata     = resp ? memWord(raddr) : 32'hDEAD_BEEF;
        #1;
        exp_req   = running && (inflight_addr.size() + outq.size() < DEPTH) && !redir;
        last_req  = bus.imem_req;
        last_addr = bus.imem_addr;
        checkOutput("imem_req", 32'(last_req), 32'(exp_req));
        if (exp_req) begin
            checkOutput("imem_addr", last_addr, model_pc);
        end

        @(posedge clk);
        if (resp) begin
            rstale = inflight_stale.pop_front();
            void'(inflight_addr.pop_front());
        end
        if (redir) begin
            outq.delete();
            foreach (inflight_stale[i]) inflight_stale[i] = 1'b1;
            model_pc = {rpc[31:2], 2'b00};
        end else begin
            if (ready && outq.size() != 0) begin
                void'(outq.pop_front());
            end
            if (resp && !rstale) begin
                outq.push_back({memWord(raddr), raddr});
            end
            if (exp_req && gnt) begin
                inflight_addr.push_back(model_pc);
                inflight_stale.push_back(1'b0);
                model_pc = model_pc + 32'd4;
            end
        end
        running = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        resetModel();
        quietInputs();
        #2 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_id_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("rst_instruction", bus.instruction_r, NOP_INSTR);
        checkOutput("rst_pc_r", bus.pc_r, 32'h0);
        checkOutput("rst_imem_req", 32'(bus.imem_req), 32'h0);
        checkOutput("rst_imem_addr", bus.imem_addr, RESET_PC);
        @(negedge clk);
        rst_n = 1'b1;

        // streaming from reset
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // backpressure: restart at 0 and let the queue fill
        applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("bp_req_stopped", 32'(last_req), 32'h0);
        checkOutput("bp_head_pc", bus.pc_r, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        checkOutput("bp_next_req", 32'(last_req), 32'h1);
        checkOutput("bp_next_addr", last_addr, 32'h10);

        // grant stall at 0x8
        applyStimulus(1'b1, 32'h8, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
            checkOutput("stall_req", 32'(last_req), 32'h1);
            checkOutput("stall_addr", last_addr, 32'h8);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        // drain, then build 2 outstanding + 1 queued and redirect to 0x1003
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h1003, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("redir_req", 32'(last_req), 32'h1);
        checkOutput("redir_addr", last_addr, 32'h1000);
        for (int i = 0; i < 20 && !bus.id_valid; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("redir_first_pc", bus.pc_r, 32'h1000);

        // redirect coinciding with a response and a pop
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 32'h2000, 1'b1, 1'b0, 1'b1);
        checkOutput("rp_id_valid", 32'(bus.id_valid), 32'h0);
        for (int i = 0; i < 20 && !bus.id_valid; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("rp_first_pc", bus.pc_r, 32'h2000);

        // random traffic with occasional redirects
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(15) == 0, $urandom, 1'($urandom_range(1)),
                          $urandom_range(3) != 0, 1'($urandom_range(1)));
        end

        // asynchronous reset in the middle of a stream
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'h0, 1'($urandom_range(1)), 1'b1, 1'b1);
        #2 rst_n = 1'b0;
        quietInputs();
        #1;
        checkOutput("async_id_valid", 32'(bus.id_valid), 32'h0);
        checkOutput("async_instruction", bus.instruction_r, NOP_INSTR);
        checkOutput("async_pc_r", bus.pc_r, 32'h0);
        checkOutput("async_imem_req", 32'(bus.imem_req), 32'h0);
        resetModel();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checkOutput("post_rst_req", 32'(last_req), 32'h1);
        checkOutput("post_rst_addr", last_addr, RESET_PC);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
